// File: rtl/cpu2core_cpu0_cpu_oci_dct_packer.sv
// Packs 2-bit OCI trace atoms into frames of up to MAX_ATOMS; frame valid 1 cycle after fill/flush/timeout.
// Backpressure: frame held stable while dct_ready=0, no atoms accepted until the cycle after the handshake.
module cpu2core_cpu0_cpu_oci_dct_packer #(
  parameter int MAX_ATOMS    = 15,
  parameter int IDLE_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        atm_valid,
  input  logic [1:0]  atm,
  output logic        atm_ready,
  input  logic        flush,
  input  logic        test_ending_in,
  output logic [29:0] dct_buffer,
  output logic [3:0]  dct_count,
  output logic        dct_valid,
  input  logic        dct_ready,
  output logic        test_ending,
  output logic        test_has_ended
);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    EMIT  = 2'd1,
    ENDED = 2'd2
  } state_t;

  localparam logic [3:0] MAX_CNT = 4'(MAX_ATOMS);

  state_t      state;
  logic        final_flag;
  logic [31:0] idle_cnt;

  logic        accept;
  logic [3:0]  count_nxt;
  logic [29:0] buffer_nxt;
  logic [31:0] idle_nxt;
  logic        timeout_hit;
  logic        frame_close;

  assign atm_ready = (state == FILL) && !test_ending_in;
  assign accept    = atm_valid && atm_ready;

  always_comb begin
    buffer_nxt  = dct_buffer;
    count_nxt   = dct_count;
    if (accept) begin
      buffer_nxt[{dct_count, 1'b0} +: 2] = atm;
      count_nxt                          = dct_count + 4'd1;
    end
    idle_nxt    = idle_cnt + 32'd1;
    timeout_hit = (IDLE_TIMEOUT != 0) && (idle_nxt == 32'(IDLE_TIMEOUT));
    // Full beats flush; both see the atom accepted this same cycle.
    frame_close = (count_nxt == MAX_CNT) || (flush && (count_nxt != 4'd0));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= FILL;
      dct_buffer     <= '0;
      dct_count      <= '0;
      dct_valid      <= 1'b0;
      test_ending    <= 1'b0;
      test_has_ended <= 1'b0;
      idle_cnt       <= '0;
      final_flag     <= 1'b0;
    end else begin
      test_ending <= test_ending_in;
      case (state)
        FILL: begin
          if (test_ending_in) begin
            idle_cnt <= '0;
            if (dct_count != 4'd0) begin
              final_flag <= 1'b1;
              dct_valid  <= 1'b1;
              state      <= EMIT;
            end else begin
              test_has_ended <= 1'b1;
              state          <= ENDED;
            end
          end else begin
            dct_buffer <= buffer_nxt;
            dct_count  <= count_nxt;
            if (frame_close) begin
              idle_cnt  <= '0;
              dct_valid <= 1'b1;
              state     <= EMIT;
            end else if (accept || (dct_count == 4'd0)) begin
              idle_cnt <= '0;
            end else if (timeout_hit) begin
              idle_cnt  <= '0;
              dct_valid <= 1'b1;
              state     <= EMIT;
            end else begin
              idle_cnt <= idle_nxt;
            end
          end
        end
        EMIT: begin
          if (test_ending_in) begin
            final_flag <= 1'b1;
          end
          if (dct_ready) begin
            dct_buffer <= '0;
            dct_count  <= '0;
            dct_valid  <= 1'b0;
            // An end request seen in the handshake cycle still makes this the last frame.
            if (final_flag || test_ending_in) begin
              test_has_ended <= 1'b1;
              state          <= ENDED;
            end else begin
              state <= FILL;
            end
          end
        end
        ENDED: begin
          dct_valid      <= 1'b0;
          test_has_ended <= 1'b1;
        end
        default: begin
          state <= FILL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu2core_cpu0_cpu_oci_dct_packer.sv
// Bench for the OCI atom packer: scenario tasks against a queue-based frame model.
module tb_cpu2core_cpu0_cpu_oci_dct_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic        atm_valid;
  logic [1:0]  atm;
  logic        atm_ready;
  logic        flush;
  logic        test_ending_in;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        dct_valid;
  logic        dct_ready;
  logic        test_ending;
  logic        test_has_ended;

  logic        to_atm_ready;
  logic [29:0] to_buffer;
  logic [3:0]  to_count;
  logic        to_valid;
  logic        to_test_ending;
  logic        to_has_ended;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpu2core_cpu0_cpu_oci_dct_packer #(.MAX_ATOMS(15), .IDLE_TIMEOUT(0)) dut (
    .clk(clk), .reset(reset), .atm_valid(atm_valid), .atm(atm), .atm_ready(atm_ready),
    .flush(flush), .test_ending_in(test_ending_in), .dct_buffer(dct_buffer),
    .dct_count(dct_count), .dct_valid(dct_valid), .dct_ready(dct_ready),
    .test_ending(test_ending), .test_has_ended(test_has_ended)
  );

  cpu2core_cpu0_cpu_oci_dct_packer #(.MAX_ATOMS(15), .IDLE_TIMEOUT(4)) dut_to (
    .clk(clk), .reset(reset), .atm_valid(atm_valid), .atm(atm), .atm_ready(to_atm_ready),
    .flush(flush), .test_ending_in(test_ending_in), .dct_buffer(to_buffer),
    .dct_count(to_count), .dct_valid(to_valid), .dct_ready(dct_ready),
    .test_ending(to_test_ending), .test_has_ended(to_has_ended)
  );

  // Frame model for the main instance (timeout disabled): pending atoms in a queue.
  int mq[$];
  bit m_pres, m_final, m_ended, m_te;

  wire [37:0] dut_vec = {atm_ready, dct_valid, dct_count, dct_buffer, test_has_ended, test_ending};

  function automatic logic [29:0] pack_q();
    longint s = 0;
    foreach (mq[i]) s += longint'(mq[i]) * (longint'(1) << (2 * i));
    return s[29:0];
  endfunction

  function automatic logic [37:0] exp_vec();
    logic rdy = !m_pres && !m_ended && !test_ending_in;
    return {rdy, m_pres, 4'(mq.size()), pack_q(), m_ended, m_te};
  endfunction

  task automatic drive(input bit v, input logic [1:0] a, input bit f, input bit r, input bit te);
    atm_valid      = v;
    atm            = a;
    flush          = f;
    dct_ready      = r;
    test_ending_in = te;
    #1;
  endtask

  task automatic tick();
    if (reset) begin
      mq.delete();
      m_pres = 0; m_final = 0; m_ended = 0; m_te = 0;
    end else begin
      if (m_ended) begin
      end else if (m_pres) begin
        if (test_ending_in) m_final = 1;
        if (dct_ready) begin
          mq.delete();
          m_pres = 0;
          if (m_final) m_ended = 1;
        end
      end else if (test_ending_in) begin
        if (mq.size() > 0) begin m_final = 1; m_pres = 1; end
        else m_ended = 1;
      end else begin
        if (atm_valid) mq.push_back(int'(atm));
        if (mq.size() == 15 || (flush && mq.size() > 0)) m_pres = 1;
      end
      m_te = test_ending_in;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, 2'd0, 0, 0, 0);
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    drive(0, 2'd0, 0, 1, 0);
    checks++;
    if (dut_vec !== {1'b1, 1'b0, 4'd0, 30'd0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL reset_state got %h exp %h", dut_vec, {1'b1, 37'd0});
    end
    checks++;
    if (dut_vec !== exp_vec()) begin
      errors++; $display("FAIL reset_model got %h exp %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_full_frame();
    do_reset();
    for (int i = 0; i < 15; i++) begin
      drive(1, 2'b01, 0, 1, 0);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL full_fill[%0d] got %h exp %h", i, dut_vec, exp_vec());
      end
      tick();
    end
    drive(1, 2'b10, 0, 1, 0);
    checks++;
    if (!(dct_valid === 1'b1 && dct_buffer === 30'h15555555 && dct_count === 4'd15 && atm_ready === 1'b0)) begin
      errors++; $display("FAIL full_frame got v=%b buf=%h cnt=%0d rdy=%b exp v=1 buf=15555555 cnt=15 rdy=0",
                         dct_valid, dct_buffer, dct_count, atm_ready);
    end
    tick();
    drive(1, 2'b10, 0, 1, 0);
    checks++;
    if (dct_valid !== 1'b0 || atm_ready !== 1'b1) begin
      errors++; $display("FAIL full_next_accept got v=%b rdy=%b exp v=0 rdy=1", dct_valid, atm_ready);
    end
    tick();
    // Random full frame, the previous atom already opened it.
    for (int i = 0; i < 15; i++) begin
      drive(1, 2'($urandom), 0, 1, 0);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL full_rand[%0d] got %h exp %h", i, dut_vec, exp_vec());
      end
      tick();
    end
  endtask

  task automatic test_flush();
    logic [1:0] seq [3];
    int k;
    seq[0] = 2'd3; seq[1] = 2'd2; seq[2] = 2'd1;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, seq[i], 0, 1, 0);
      tick();
    end
    drive(0, 2'd0, 1, 1, 0);
    tick();
    drive(0, 2'd0, 0, 1, 0);
    checks++;
    if (!(dct_valid === 1'b1 && dct_buffer === 30'h0000001B && dct_count === 4'd3)) begin
      errors++; $display("FAIL flush_partial got v=%b buf=%h cnt=%0d exp v=1 buf=0000001b cnt=3",
                         dct_valid, dct_buffer, dct_count);
    end
    tick();
    drive(0, 2'd0, 1, 1, 0);
    tick();
    drive(0, 2'd0, 0, 1, 0);
    checks++;
    if (dct_valid !== 1'b0 || dut_vec !== exp_vec()) begin
      errors++; $display("FAIL flush_empty got %h exp %h", dut_vec, exp_vec());
    end
    tick();
    k = $urandom_range(1, 13);
    for (int i = 0; i < k; i++) begin
      drive(1, 2'($urandom), (i == k - 1), 1, 0);
      tick();
    end
    drive(0, 2'd0, 0, 1, 0);
    checks++;
    if (dct_valid !== 1'b1 || dct_count !== 4'(k) || dut_vec !== exp_vec()) begin
      errors++; $display("FAIL flush_same_cycle got %h exp %h (k=%0d)", dut_vec, exp_vec(), k);
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [37:0] snap;
    do_reset();
    for (int i = 0; i < 15; i++) begin
      drive(1, 2'($urandom), 0, 0, 0);
      tick();
    end
    for (int b = 0; b < 6; b++) begin
      drive(1, 2'($urandom), 0, (b == 5), 0);
      if (b == 0) snap = dut_vec;
      checks++;
      if (dut_vec !== exp_vec() || dut_vec !== snap || atm_ready !== 1'b0 || dct_valid !== 1'b1) begin
        errors++; $display("FAIL backpressure[%0d] got %h exp %h", b, dut_vec, exp_vec());
      end
      tick();
    end
    drive(1, 2'($urandom), 0, 1, 0);
    checks++;
    if (atm_ready !== 1'b1 || dct_valid !== 1'b0) begin
      errors++; $display("FAIL backpressure_release got rdy=%b v=%b exp rdy=1 v=0", atm_ready, dct_valid);
    end
    tick();
  endtask

  task automatic test_end_of_test();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1, 2'($urandom), 0, 1, 0);
      tick();
    end
    drive(1, 2'd1, 0, 1, 1);
    checks++;
    if (atm_ready !== 1'b0) begin
      errors++; $display("FAIL end_ready got %b exp 0", atm_ready);
    end
    tick();
    drive(1, 2'd1, 0, 1, 1);
    checks++;
    if (dct_valid !== 1'b1 || dct_count !== 4'd2 || test_ending !== 1'b1 || dut_vec !== exp_vec()) begin
      errors++; $display("FAIL end_frame got %h exp %h", dut_vec, exp_vec());
    end
    tick();
    for (int i = 0; i < 10; i++) begin
      drive(1, 2'($urandom), 0, 1, (i < 5));
      checks++;
      if (test_has_ended !== 1'b1 || atm_ready !== 1'b0 || dct_valid !== 1'b0 || dut_vec !== exp_vec()) begin
        errors++; $display("FAIL end_ended[%0d] got %h exp %h", i, dut_vec, exp_vec());
      end
      tick();
    end
    do_reset();
    drive(0, 2'd0, 0, 1, 1);
    checks++;
    if (test_has_ended !== 1'b0) begin
      errors++; $display("FAIL end_empty_pre got %b exp 0", test_has_ended);
    end
    tick();
    drive(0, 2'd0, 0, 1, 1);
    checks++;
    if (test_has_ended !== 1'b1 || dct_valid !== 1'b0 || dut_vec !== exp_vec()) begin
      errors++; $display("FAIL end_empty got %h exp %h", dut_vec, exp_vec());
    end
    tick();
  endtask

  task automatic test_idle_timeout();
    do_reset();
    drive(1, 2'($urandom), 0, 1, 0);
    tick();
    for (int k = 1; k <= 20; k++) begin
      drive(0, 2'd0, 0, 1, 0);
      if (k <= 6) begin
        checks++;
        if (to_valid !== (k == 5) || (k == 5 && to_count !== 4'd1)) begin
          errors++; $display("FAIL timeout4 N+%0d got v=%b cnt=%0d exp v=%b cnt=1", k, to_valid, to_count, (k == 5));
        end
      end
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL timeout0 N+%0d got %h exp %h", k, dut_vec, exp_vec());
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 15; i++) begin
      drive(1, 2'($urandom), 0, 0, 0);
      tick();
    end
    reset = 1'b1;
    drive(0, 2'd0, 0, 0, 0);
    tick();
    reset = 1'b0;
    drive(0, 2'd0, 0, 0, 0);
    checks++;
    if (dct_valid !== 1'b0 || dct_count !== 4'd0 || test_has_ended !== 1'b0 || atm_ready !== 1'b1) begin
      errors++; $display("FAIL reset_mid got v=%b cnt=%0d ended=%b rdy=%b exp 0 0 0 1",
                         dct_valid, dct_count, test_has_ended, atm_ready);
    end
    tick();
  endtask

  task automatic test_random_stream();
    for (int r = 0; r < 4; r++) begin
      do_reset();
      for (int i = 0; i < 400; i++) begin
        drive(($urandom_range(0, 3) != 0), 2'($urandom), ($urandom_range(0, 9) == 0),
              ($urandom_range(0, 2) != 0), (i >= 360 - 40 * r));
        checks++;
        if (dut_vec !== exp_vec()) begin
          errors++; $display("FAIL random r%0d c%0d got %h exp %h", r, i, dut_vec, exp_vec());
        end
        tick();
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 2'd0, 0, 0, 0);
    @(negedge clk);
    test_reset();
    test_full_frame();
    test_flush();
    test_backpressure();
    test_end_of_test();
    test_idle_timeout();
    test_reset_mid();
    test_random_stream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu2core_cpu0_cpu_oci_dct_packer.md
# cpu2core_cpu0_cpu_oci_dct_packer

Packs the CPU0 OCI data-trace atom stream into compressed trace frames: up to 15 two-bit atoms in a 30-bit buffer, plus an atom count. It sits directly upstream of the OCI trace test-bench/sink and drives its `dct_buffer`, `dct_count`, `test_ending` and `test_has_ended` inputs. A valid/ready handshake lets the sink apply backpressure. End-of-test sequencing guarantees that the last partial frame is drained before `test_has_ended` is raised.

## Interface
- `MAX_ATOMS`, default 15: atoms per full frame. Legal range is 1..15.
- `IDLE_TIMEOUT`, default 0: number of idle cycles before a partial frame is auto-emitted. 0 disables the timeout.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `reset`  in  1  reset is synchronous and active-high.
- `atm_valid`  in  1  an atom is offered.
- `atm`  in  2  trace atom payload.
- `atm_ready`  out  1  packer accepts the atom this cycle.
- `flush`  in  1  single-cycle request to emit the current partial frame.
- `test_ending_in`  in  1  level; end of test requested.
- `dct_buffer`  out  30  packed atoms; atom i is at bits [2i+1:2i]; unused bits are 0.
- `dct_count`  out  4  number of atoms in `dct_buffer`.
- `dct_valid`  out  1  frame is presented.
- `dct_ready`  in  1  sink accepts the frame.
- `test_ending`  out  1  registered copy of `test_ending_in`, forwarded to the sink.
- `test_has_ended`  out  1  final frame has been drained; sticky until reset.

## Operation
- **Reset values:** state FILL; `dct_buffer`=0; `dct_count`=0; `dct_valid`=0; `test_ending`=0; `test_has_ended`=0; idle counter=0; final flag=0.
- **Acceptance:** an atom is accepted when `atm_valid` & `atm_ready`.
- **Ready rule:** `atm_ready` = (state==FILL) & !`test_ending_in`.
- **FILL state:**
  - On accept, write `atm` to slot `dct_count` and increment `dct_count`.
  - If the count reaches `MAX_ATOMS`, go to EMIT.
  - If `flush`=1 and the post-accept count is >0, go to EMIT. This includes an atom accepted in the same cycle.
  - `flush` with count 0 is ignored.
  - **Idle timeout:** the idle counter clears on every accept and on leaving FILL. It increments while count>0 and no atom is accepted. When `IDLE_TIMEOUT`≠0 and the counter reaches `IDLE_TIMEOUT`, go to EMIT.
  - **End of test:** if `test_ending_in`=1, accept no atom. If count>0, set the final flag and go to EMIT; otherwise go to ENDED.
- **EMIT state:**
  - `dct_valid`=1 and `atm_ready`=0.
  - `dct_buffer` and `dct_count` are held stable until the handshake.
  - On `dct_ready`, clear buffer and count, then go to ENDED if the final flag is set, else to FILL.
  - If `test_ending_in` rises during EMIT, set the final flag. The current frame is then the last one.
- **ENDED state:** `test_has_ended`=1, `atm_ready`=0, `dct_valid`=0. The block stays in ENDED until `reset`.
- **Priority within one FILL cycle:** `test_ending_in` > full > `flush` > timeout.
- **Reset mid-operation:** any pending frame is discarded and all outputs return to their reset values on the next edge.
- **Out-of-frame outputs:** `dct_buffer`/`dct_count` outside EMIT show the in-progress contents. The sink ignores them unless `dct_valid`=1.

## Timing
- **Emit latency:** an atom that completes a frame, or a `flush`, in cycle N gives `dct_valid`=1 in cycle N+1.
- **Throughput:** at least one bubble per frame. The earliest next accept is the cycle after the handshake. Sustained full-frame rate is 15 atoms per 16 cycles.
- **`test_ending`:** lags `test_ending_in` by 1 cycle.
- **`test_has_ended`:**
  - Rises 1 cycle after the final frame handshake.
  - Rises 1 cycle after `test_ending_in` when the buffer is empty.
- **Timeout:** with one atom accepted in cycle N and no further atoms, `dct_valid` rises in cycle N+`IDLE_TIMEOUT`+1.
- **Backpressure:** while `dct_valid`=1 and `dct_ready`=0, all outputs are stable and no atom is accepted.

## Test plan
- **Full frame:** 15 consecutive atoms of 2'b01, `dct_ready`=1 -> `dct_valid` for exactly 1 cycle with `dct_buffer`=30'h15555555 and `dct_count`=15. The next atom is accepted 2 cycles after the 15th.
- **Flush with partial frame:** atoms 3, 2, 1, then `flush` -> `dct_buffer`=30'h0000001B, `dct_count`=3. A second `flush` with count 0 produces no frame.
- **Backpressure:** full frame with `dct_ready` held low 5 cycles -> `dct_valid`, `dct_buffer` and `dct_count` stable, `atm_ready`=0. Handshake on the 6th cycle, then `atm_ready`=1 the following cycle.
- **End of test:** 2 atoms pending, then `test_ending_in`=1 -> frame with count 2. `test_has_ended`=1 one cycle after the handshake; later `atm_valid` is never accepted. Repeat with an empty buffer -> `test_has_ended`=1 one cycle after `test_ending_in`.
- **Idle timeout:** `IDLE_TIMEOUT`=4, one atom then idle -> `dct_valid`=1 in cycle N+5 with `dct_count`=1. With `IDLE_TIMEOUT`=0, the same stimulus never emits.
- **Reset mid-operation:** assert `reset` during EMIT -> next cycle `dct_valid`=0, `dct_count`=0, `test_has_ended`=0, `atm_ready`=1.
